// File: rtl/vram_pkg.sv
// ----------------------------------------------------------------------------
// vram_pkg
//   Shared definitions for the video RAM write path: default RAM geometry
//   (kept here so the RAM instance and the arbiter cannot drift apart) and
//   the encoding of the fill engine's state machine.
// ----------------------------------------------------------------------------
package vram_pkg;

    localparam int VRAM_DATA_WIDTH   = 8;
    localparam int VRAM_ADDR_WIDTH   = 8;
    localparam int VRAM_CPU_BUF_LOG2 = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/vram_cpu_fifo.sv
// ----------------------------------------------------------------------------
// vram_cpu_fifo
//   Small synchronous FIFO that buffers CPU bus-snoop writes until the
//   arbiter can issue them. Depth is 2**DEPTH_LOG2.
//
// Ports
//   i_clk     in   1             clock
//   i_rst_n   in   1             asynchronous active-low reset (empties FIFO)
//   i_push    in   1             write i_data (ignored when full unless i_pop)
//   i_pop     in   1             discard the head entry (ignored when empty)
//   i_data    in   WIDTH         entry to push
//   o_head    out  WIDTH         oldest entry
//   o_full    out  1             registered: FIFO holds DEPTH entries
//   o_empty   out  1             registered: FIFO holds no entries
//   o_count   out  DEPTH_LOG2+1  registered occupancy
// ----------------------------------------------------------------------------
module vram_cpu_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_data,
    output logic [WIDTH-1:0]      o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_do_push;
    logic                  w_do_pop;
    logic [DEPTH_LOG2:0]   w_count_next;

    // A push into a full FIFO is only accepted when the head leaves in the
    // same cycle; the freed slot is the one the write pointer points at.
    assign w_do_push = i_push && (!r_full || i_pop);
    assign w_do_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/vram_write_arbiter.sv
// ----------------------------------------------------------------------------
// vram_write_arbiter
//   Owns the write port of the dual-clock video RAM. Merges CPU snoop writes
//   (buffered, no backpressure), host loader writes (valid/ready) and a fill
//   engine that writes one value to every RAM word. Priority per issue slot:
//   buffered CPU > host > fill. RAM write signals come straight from flops.
//
// Ports
//   i_clk            in   1    write clock (RAM write clock)
//   i_rst_n          in   1    asynchronous active-low reset
//   i_cpu_we         in   1    one-cycle CPU write strobe
//   i_cpu_addr       in   AW   CPU write address
//   i_cpu_data       in   DW   CPU write data
//   i_host_valid     in   1    host write request
//   o_host_ready     out  1    host accepted when valid && ready
//   i_host_addr      in   AW   host write address
//   i_host_data      in   DW   host write data
//   i_fill_start     in   1    pulse: start a full-RAM fill
//   i_fill_value     in   DW   fill word, latched when a fill starts
//   o_fill_busy      out  1    fill in progress
//   o_fill_done      out  1    pulse alongside the final fill write
//   o_cpu_overflow   out  1    sticky: a CPU write was dropped
//   o_ram_data       out  DW   RAM data input
//   o_ram_write_addr out  AW   RAM write address
//   o_ram_we         out  1    RAM write enable
// ----------------------------------------------------------------------------
module vram_write_arbiter
    import vram_pkg::*;
#(
    parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
    parameter int CPU_BUF_LOG2 = VRAM_CPU_BUF_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_data,
    input  logic                  i_host_valid,
    output logic                  o_host_ready,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_data,
    input  logic                  i_fill_start,
    input  logic [DATA_WIDTH-1:0] i_fill_value,
    output logic                  o_fill_busy,
    output logic                  o_fill_done,
    output logic                  o_cpu_overflow,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic [ADDR_WIDTH-1:0] o_ram_write_addr,
    output logic                  o_ram_we
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [EW-1:0]           w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [CPU_BUF_LOG2:0]   w_count;

    logic                    w_pop;
    logic                    w_host_win;
    logic                    w_fill_win;
    logic                    w_fill_last;

    fill_state_e             r_state;
    fill_state_e             w_state_next;
    logic [ADDR_WIDTH:0]     r_fill_cnt;
    logic [ADDR_WIDTH:0]     w_fill_cnt_next;
    logic [DATA_WIDTH-1:0]   r_fill_value;
    logic [DATA_WIDTH-1:0]   w_fill_value_next;

    logic [DATA_WIDTH-1:0]   r_ram_data;
    logic [ADDR_WIDTH-1:0]   r_ram_addr;
    logic                    r_ram_we;
    logic                    r_fill_done;
    logic                    r_overflow;

    vram_cpu_fifo #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (CPU_BUF_LOG2)
    ) u_cpu_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_cpu_we),
        .i_pop   (w_pop),
        .i_data  ({i_cpu_addr, i_cpu_data}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Issue slot arbitration. Everything feeding the decision except the
    // host request is registered, so host_ready never sees cpu_we or
    // host_valid combinationally. The top bit of the fill counter marks
    // "all words written" and blocks a further fill write.
    assign w_pop       = !w_empty;
    assign w_host_win  = w_empty && i_host_valid;
    assign w_fill_win  = w_empty && !i_host_valid && (r_state == ST_FILL)
                         && !r_fill_cnt[ADDR_WIDTH];
    assign w_fill_last = (r_fill_cnt[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

    assign o_host_ready = (w_count == '0);

    // Fill FSM next state: start latches the value and clears the counter;
    // the counter only advances on cycles the fill actually writes; the
    // cycle after the last write returns to idle. Starts while filling are
    // ignored.
    always_comb begin
        w_state_next      = r_state;
        w_fill_cnt_next   = r_fill_cnt;
        w_fill_value_next = r_fill_value;
        case (r_state)
            ST_IDLE: begin
                if (i_fill_start) begin
                    w_state_next      = ST_FILL;
                    w_fill_cnt_next   = '0;
                    w_fill_value_next = i_fill_value;
                end
            end
            ST_FILL: begin
                if (w_fill_win) begin
                    w_fill_cnt_next = r_fill_cnt + 1'b1;
                end else if (r_fill_cnt[ADDR_WIDTH]) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_fill_cnt   <= '0;
            r_fill_value <= '0;
        end else begin
            r_state      <= w_state_next;
            r_fill_cnt   <= w_fill_cnt_next;
            r_fill_value <= w_fill_value_next;
        end
    end

    // RAM port registers. Address and data hold their last value on idle
    // cycles. Overflow can only occur if a push meets a full buffer that is
    // not being drained in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ram_data  <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_fill_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_ram_we    <= w_pop || w_host_win || w_fill_win;
            r_fill_done <= w_fill_win && w_fill_last;
            if (w_pop) begin
                r_ram_addr <= w_head[EW-1:DATA_WIDTH];
                r_ram_data <= w_head[DATA_WIDTH-1:0];
            end else if (w_host_win) begin
                r_ram_addr <= i_host_addr;
                r_ram_data <= i_host_data;
            end else if (w_fill_win) begin
                r_ram_addr <= r_fill_cnt[ADDR_WIDTH-1:0];
                r_ram_data <= r_fill_value;
            end
            if (i_cpu_we && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_ram_we         = r_ram_we;
    assign o_ram_data       = r_ram_data;
    assign o_ram_write_addr = r_ram_addr;
    assign o_fill_done      = r_fill_done;
    assign o_fill_busy      = (r_state == ST_FILL);
    assign o_cpu_overflow   = r_overflow;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_write_arbiter
//   Directed bench for vram_write_arbiter with default geometry (8-bit data,
//   8-bit address, 4-deep CPU buffer). Inputs change 1 time unit after a
//   rising edge; outputs are checked at that same point.
// ----------------------------------------------------------------------------
module tb_vram_write_arbiter;

    logic       clk;
    logic       rstN;
    logic       cpuWe;
    logic [7:0] cpuAddr;
    logic [7:0] cpuData;
    logic       hostValid;
    logic       hostReady;
    logic [7:0] hostAddr;
    logic [7:0] hostData;
    logic       fillStart;
    logic [7:0] fillValue;
    logic       fillBusy;
    logic       fillDone;
    logic       cpuOverflow;
    logic [7:0] ramData;
    logic [7:0] ramAddr;
    logic       ramWe;

    int nChecks = 0;
    int nFails  = 0;

    vram_write_arbiter dut (
        .i_clk            (clk),
        .i_rst_n          (rstN),
        .i_cpu_we         (cpuWe),
        .i_cpu_addr       (cpuAddr),
        .i_cpu_data       (cpuData),
        .i_host_valid     (hostValid),
        .o_host_ready     (hostReady),
        .i_host_addr      (hostAddr),
        .i_host_data      (hostData),
        .i_fill_start     (fillStart),
        .i_fill_value     (fillValue),
        .o_fill_busy      (fillBusy),
        .o_fill_done      (fillDone),
        .o_cpu_overflow   (cpuOverflow),
        .o_ram_data       (ramData),
        .o_ram_write_addr (ramAddr),
        .o_ram_we         (ramWe)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic       we,
                                 input logic [7:0] cAddr,
                                 input logic [7:0] cData,
                                 input logic       hValid,
                                 input logic [7:0] hAddr,
                                 input logic [7:0] hData,
                                 input logic       fStart,
                                 input logic [7:0] fValue);
        cpuWe     = we;
        cpuAddr   = cAddr;
        cpuData   = cData;
        hostValid = hValid;
        hostAddr  = hAddr;
        hostData  = hData;
        fillStart = fStart;
        fillValue = fValue;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Checks one RAM write: enable, address, data
    task automatic checkWrite(input string tag, input logic [7:0] addr, input logic [7:0] data);
        checkOutput({tag, "_we"},   32'(ramWe),   32'd1);
        checkOutput({tag, "_addr"}, 32'(ramAddr), 32'(addr));
        checkOutput({tag, "_data"}, 32'(ramData), 32'(data));
    endtask

    int expAddr;

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        waitCycle();
        waitCycle();
        rstN = 1'b1;

        // Idle after reset release
        $display("[TB] idle after reset");
        for (int i = 0; i < 10; i++) begin
            waitCycle();
            checkOutput("idle_we",    32'(ramWe),       32'd0);
            checkOutput("idle_ready", 32'(hostReady),   32'd1);
            checkOutput("idle_busy",  32'(fillBusy),    32'd0);
            checkOutput("idle_ovf",   32'(cpuOverflow), 32'd0);
        end

        // Simultaneous CPU and host write: host first, CPU next
        $display("[TB] cpu and host same cycle");
        applyStimulus(1'b1, 8'h12, 8'hA5, 1'b1, 8'h34, 8'h5A, 1'b0, 8'h00);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        checkWrite("t2_host", 8'h34, 8'h5A);
        checkOutput("t2_ready_after_push", 32'(hostReady), 32'd0);
        waitCycle();
        checkWrite("t2_cpu", 8'h12, 8'hA5);
        checkOutput("t2_ready_drained", 32'(hostReady), 32'd1);
        waitCycle();
        checkOutput("t2_idle_we",   32'(ramWe),   32'd0);
        checkOutput("t2_hold_addr", 32'(ramAddr), 32'h12);
        checkOutput("t2_hold_data", 32'(ramData), 32'hA5);

        // Six back-to-back CPU writes with the host waiting behind them
        $display("[TB] cpu burst with host pending");
        applyStimulus(1'b1, 8'h50, 8'hC0, 1'b0, 8'h77, 8'h99, 1'b0, 8'h00);
        waitCycle();
        checkOutput("t3_ready_first", 32'(hostReady), 32'd0);
        checkOutput("t3_we_first",    32'(ramWe),     32'd0);
        for (int j = 1; j <= 6; j++) begin
            if (j <= 5)
                applyStimulus(1'b1, 8'(8'h50 + j), 8'(8'hC0 + j), 1'b1, 8'h77, 8'h99, 1'b0, 8'h00);
            else
                applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h77, 8'h99, 1'b0, 8'h00);
            waitCycle();
            checkWrite($sformatf("t3_cpu%0d", j - 1), 8'(8'h50 + j - 1), 8'(8'hC0 + j - 1));
            checkOutput($sformatf("t3_ready%0d", j), 32'(hostReady), (j == 6) ? 32'd1 : 32'd0);
        end
        waitCycle();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        checkWrite("t3_host", 8'h77, 8'h99);
        checkOutput("t3_ovf", 32'(cpuOverflow), 32'd0);

        // Plain fill with 0x20; the live fill_value input changes afterwards
        $display("[TB] full fill");
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20);
        waitCycle();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'hEE);
        checkOutput("t4_busy_start", 32'(fillBusy), 32'd1);
        checkOutput("t4_we_start",   32'(ramWe),    32'd0);
        for (int i = 0; i < 256; i++) begin
            waitCycle();
            checkWrite("t4_fill", 8'(i), 8'h20);
            checkOutput("t4_done", 32'(fillDone), (i == 255) ? 32'd1 : 32'd0);
            checkOutput("t4_busy", 32'(fillBusy), 32'd1);
        end
        waitCycle();
        checkOutput("t4_busy_end", 32'(fillBusy), 32'd0);
        checkOutput("t4_we_end",   32'(ramWe),    32'd0);
        checkOutput("t4_done_end", 32'(fillDone), 32'd0);

        // Fill with a CPU write and a second fill_start injected at 0x40
        $display("[TB] fill with cpu pre-emption");
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3C);
        waitCycle();
        expAddr = 0;
        for (int t = 1; t <= 257; t++) begin
            if (t == 8'h40)
                applyStimulus(1'b1, 8'hEE, 8'h11, 1'b0, 8'h00, 8'h00, 1'b1, 8'h99);
            else
                applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h99);
            waitCycle();
            if (t == 8'h41) begin
                checkWrite("t5_cpu", 8'hEE, 8'h11);
                checkOutput("t5_cpu_done", 32'(fillDone), 32'd0);
            end else begin
                checkWrite("t5_fill", 8'(expAddr), 8'h3C);
                checkOutput("t5_done", 32'(fillDone), (expAddr == 255) ? 32'd1 : 32'd0);
                expAddr++;
            end
            checkOutput("t5_busy", 32'(fillBusy), 32'd1);
        end
        waitCycle();
        checkOutput("t5_busy_end", 32'(fillBusy), 32'd0);
        checkOutput("t5_we_end",   32'(ramWe),    32'd0);

        // Reset mid-fill at counter 0x80 with a CPU write still buffered
        $display("[TB] reset mid-fill");
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h55);
        waitCycle();
        for (int t = 1; t <= 8'h80; t++) begin
            applyStimulus((t == 8'h80), 8'hAB, 8'hCD, 1'b0, 8'h00, 8'h00, 1'b0, 8'h55);
            waitCycle();
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        checkWrite("t6_pre", 8'h7F, 8'h55);
        checkOutput("t6_pre_ready", 32'(hostReady), 32'd0);
        rstN = 1'b0;
        #1;
        checkOutput("t6_rst_we",    32'(ramWe),       32'd0);
        checkOutput("t6_rst_addr",  32'(ramAddr),     32'd0);
        checkOutput("t6_rst_data",  32'(ramData),     32'd0);
        checkOutput("t6_rst_busy",  32'(fillBusy),    32'd0);
        checkOutput("t6_rst_done",  32'(fillDone),    32'd0);
        checkOutput("t6_rst_ovf",   32'(cpuOverflow), 32'd0);
        checkOutput("t6_rst_ready", 32'(hostReady),   32'd1);
        waitCycle();
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            waitCycle();
            checkOutput("t6_post_we",    32'(ramWe),     32'd0);
            checkOutput("t6_post_busy",  32'(fillBusy),  32'd0);
            checkOutput("t6_post_ready", 32'(hostReady), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
